inst_fetch_unit: RTL

//   Consumer-side fetch engine for the PC register in the datapath.
//   - Owns the fetch address and issues word reads to instruction memory over a req/ack handshake.
//   - Buffers returned words in a small FIFO and presents them to the decoder with valid/ready.
//   - Redirect (branch/jump) flushes the FIFO and restarts fetch at the target.

---
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the fetch PC, reads instruction words over req/ack and buffers them for the decoder
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous, active-high reset
//   i_redirect_valid load a new fetch target this cycle (flushes buffered words)
//   i_redirect_pc    new fetch target; low two bits are ignored
//   o_mem_req        read request to instruction memory
//   o_mem_addr       word-aligned read address, held until the ack cycle
//   i_mem_ack        request complete; i_mem_rdata valid this cycle
//   i_mem_rdata      returned instruction word
//   o_inst_valid     o_inst_data / o_inst_pc valid to the decoder
//   o_inst_data      instruction word at the buffer head
//   o_inst_pc        address of o_inst_data
//   i_inst_ready     decoder accepts the head word when o_inst_valid=1
//
// Build option:
//   IFU_BYPASS_EN    when defined, an acked word is forwarded straight to the decoder
//                    if the buffer is empty, and is not buffered if the decoder takes it.
module inst_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst_data,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_drop_addr;
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_count_next;
    logic              w_empty, w_bypass, w_push, w_pop;

    assign w_empty = (r_count == '0);

`ifdef IFU_BYPASS_EN
    assign w_bypass     = w_empty && (r_state == REQ) && i_mem_ack && !i_redirect_valid;
    assign o_inst_valid = !w_empty || w_bypass;
    assign o_inst_data  = w_bypass ? i_mem_rdata : r_fifo_data[r_rd_ptr];
    assign o_inst_pc    = w_bypass ? r_fetch_pc  : r_fifo_pc[r_rd_ptr];
`else
    assign w_bypass     = 1'b0;
    assign o_inst_valid = !w_empty;
    assign o_inst_data  = r_fifo_data[r_rd_ptr];
    assign o_inst_pc    = r_fifo_pc[r_rd_ptr];
`endif

    // A forwarded word the decoder takes immediately never enters the buffer.
    assign w_push       = (r_state == REQ) && i_mem_ack && !i_redirect_valid && !(w_bypass && i_inst_ready);
    assign w_pop        = !w_empty && i_inst_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // DROP keeps presenting the abandoned address until memory finishes it.
    assign o_mem_req  = (r_state != IDLE);
    assign o_mem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_redirect_valid || r_count < FULL) w_next_state = REQ;
            REQ:     if (i_redirect_valid) w_next_state = i_mem_ack ? REQ : DROP;
                     else if (i_mem_ack) w_next_state = (w_count_next < FULL) ? REQ : IDLE;
            DROP:    if (i_mem_ack) w_next_state = REQ;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            // Snapshot the outstanding address so it stays frozen once DROP is entered.
            if (r_state != DROP) r_drop_addr <= r_fetch_pc;
            if (i_redirect_valid) r_fetch_pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
            else if (r_state == REQ && i_mem_ack) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= i_mem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end
endmodule
